// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: ASCII codes, state encoding,
// command bit indices and the echo-character helper.
package uart_cmd_pkg;

    localparam int CMD_NUM  = 6;
    localparam int CMD_RUN  = 0;
    localparam int CMD_CLR  = 1;
    localparam int CMD_HOUR = 2;
    localparam int CMD_MIN  = 3;
    localparam int CMD_SEC  = 4;
    localparam int CMD_TRIG = 5;

    localparam logic [7:0] ASCII_R_UP  = 8'h52;
    localparam logic [7:0] ASCII_R_LO  = 8'h72;
    localparam logic [7:0] ASCII_C_UP  = 8'h43;
    localparam logic [7:0] ASCII_C_LO  = 8'h63;
    localparam logic [7:0] ASCII_H_UP  = 8'h48;
    localparam logic [7:0] ASCII_H_LO  = 8'h68;
    localparam logic [7:0] ASCII_M_UP  = 8'h4D;
    localparam logic [7:0] ASCII_M_LO  = 8'h6D;
    localparam logic [7:0] ASCII_S_UP  = 8'h53;
    localparam logic [7:0] ASCII_S_LO  = 8'h73;
    localparam logic [7:0] ASCII_T_UP  = 8'h54;
    localparam logic [7:0] ASCII_T_LO  = 8'h74;
    localparam logic [7:0] ASCII_W_UP  = 8'h57;
    localparam logic [7:0] ASCII_W_LO  = 8'h77;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_PULSE  = 3'd4;
    localparam logic [2:0] ST_ECHO   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_POP    = ST_POP,
        S_LATCH  = ST_LATCH,
        S_DECODE = ST_DECODE,
        S_PULSE  = ST_PULSE,
        S_ECHO   = ST_ECHO
    } state_t;

    // Recognised bytes echo verbatim; anything else echoes as '?'.
    function automatic logic [7:0] echo_char(input logic [7:0] data, input logic known);
        if (known) begin
            return data;
        end else begin
            return ASCII_QMARK;
        end
    endfunction

endpackage

// File: rtl/uart_cmd_parser_lut.sv
// Combinational byte decoder: maps an ASCII byte to a one-hot command,
// a mode-toggle flag and a CR/LF terminator flag.
module uart_cmd_lut
    import uart_cmd_pkg::*;
(
    input  logic [7:0]         data,
    output logic               valid,
    output logic               is_mode,
    output logic               is_term,
    output logic [CMD_NUM-1:0] onehot
);

    // Case-insensitive command lookup.
    always_comb begin
        valid   = 1'b0;
        is_mode = 1'b0;
        is_term = 1'b0;
        onehot  = {CMD_NUM{1'b0}};
        case (data)
            ASCII_R_UP, ASCII_R_LO: begin valid = 1'b1; onehot[CMD_RUN]  = 1'b1; end
            ASCII_C_UP, ASCII_C_LO: begin valid = 1'b1; onehot[CMD_CLR]  = 1'b1; end
            ASCII_H_UP, ASCII_H_LO: begin valid = 1'b1; onehot[CMD_HOUR] = 1'b1; end
            ASCII_M_UP, ASCII_M_LO: begin valid = 1'b1; onehot[CMD_MIN]  = 1'b1; end
            ASCII_S_UP, ASCII_S_LO: begin valid = 1'b1; onehot[CMD_SEC]  = 1'b1; end
            ASCII_T_UP, ASCII_T_LO: begin valid = 1'b1; onehot[CMD_TRIG] = 1'b1; end
            ASCII_W_UP, ASCII_W_LO: is_mode = 1'b1;
            ASCII_CR, ASCII_LF:     is_term = 1'b1;
            default:                valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: pops bytes from the RX FIFO, decodes single-character
// commands into fixed-width one-hot pulses and a mode level. Optional echo: UART_CMD_ECHO_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_empty,
    input  logic [7:0]         rx_rdata,
    output logic               rx_rd,
    input  logic               tx_full,
    output logic [7:0]         tx_wdata,
    output logic               tx_wr,
    output logic [CMD_NUM-1:0] cmd_pulse,
    output logic               mode_sel
);

`ifdef UART_CMD_ECHO_EN
    localparam state_t DONE_ST = S_ECHO;
`else
    localparam state_t DONE_ST = S_IDLE;
`endif

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r, state_s;
    logic               empty_r;
    logic [7:0]         byte_r, byte_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [CMD_NUM-1:0] cmd_r, cmd_s;
    logic               mode_r, mode_s;
    logic               rx_rd_r, rx_rd_s;
    logic               valid_s, is_mode_s, is_term_s;
    logic [CMD_NUM-1:0] onehot_s;

    uart_cmd_lut u_lut (
        .data    (byte_r),
        .valid   (valid_s),
        .is_mode (is_mode_s),
        .is_term (is_term_s),
        .onehot  (onehot_s)
    );

`ifdef UART_CMD_ECHO_EN
    logic       tx_wr_r, tx_wr_s;
    logic [7:0] tx_wdata_r, tx_wdata_s;
`endif

    // Next-state and next-output logic; every output is the registered image of these.
    always_comb begin
        state_s = state_r;
        byte_s  = byte_r;
        cnt_s   = cnt_r;
        cmd_s   = {CMD_NUM{1'b0}};
        mode_s  = mode_r;
`ifdef UART_CMD_ECHO_EN
        tx_wr_s    = 1'b0;
        tx_wdata_s = tx_wdata_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (!empty_r) begin
                    state_s = S_POP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_POP: state_s = S_LATCH;
            S_LATCH: begin
                byte_s  = rx_rdata;
                state_s = S_DECODE;
            end
            S_DECODE: begin
                if (valid_s) begin
                    cnt_s   = CNT_LOAD;
                    cmd_s   = onehot_s;
                    state_s = S_PULSE;
                end else begin
                    if (is_mode_s) begin
                        mode_s = ~mode_r;
                    end else begin
                        mode_s = mode_r;
                    end
                    state_s = DONE_ST;
                end
            end
            S_PULSE: begin
                if (cnt_r == CNT_ONE) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = DONE_ST;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                    cmd_s   = cmd_r;
                end
            end
`ifdef UART_CMD_ECHO_EN
            S_ECHO: begin
                if (!tx_full) begin
                    tx_wr_s    = 1'b1;
                    tx_wdata_s = echo_char(byte_r, valid_s | is_mode_s | is_term_s);
                    state_s    = S_IDLE;
                end else begin
                    state_s    = S_ECHO;
                end
            end
`endif
            default: state_s = S_IDLE;
        endcase
        rx_rd_s = (state_s == S_POP);
    end

    // Core state and registered outputs; empty flag is sampled before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            empty_r <= 1'b1;
            byte_r  <= 8'h00;
            cnt_r   <= {CNT_W{1'b0}};
            cmd_r   <= {CMD_NUM{1'b0}};
            mode_r  <= 1'b0;
            rx_rd_r <= 1'b0;
        end else begin
            state_r <= state_s;
            empty_r <= rx_empty;
            byte_r  <= byte_s;
            cnt_r   <= cnt_s;
            cmd_r   <= cmd_s;
            mode_r  <= mode_s;
            rx_rd_r <= rx_rd_s;
        end
    end

`ifdef UART_CMD_ECHO_EN
    // Echo write port registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_r    <= 1'b0;
            tx_wdata_r <= 8'h00;
        end else begin
            tx_wr_r    <= tx_wr_s;
            tx_wdata_r <= tx_wdata_s;
        end
    end

    assign tx_wr    = tx_wr_r;
    assign tx_wdata = tx_wdata_r;
`else
    logic unused_s;
    assign unused_s = ^{tx_full, is_term_s};
    assign tx_wr    = 1'b0;
    assign tx_wdata = 8'h00;
`endif

    assign rx_rd     = rx_rd_r;
    assign cmd_pulse = cmd_r;
    assign mode_sel  = mode_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table vectors, hand-written corner
// sequences and randomized byte streams against a rule-level reference model.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_empty;
    logic [7:0] rx_rdata = 8'h00;
    logic       rx_rd;
    logic       tx_full = 1'b0;
    logic [7:0] tx_wdata;
    logic       tx_wr;
    logic [5:0] cmd_pulse;
    logic       mode_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model: main writes mem/wr_ptr, monitor owns rd_ptr/rx_rdata
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rx_empty = (wr_ptr == rd_ptr);

    // Logs written only by the monitor
    logic [7:0] tx_log [0:1023];
    int pl_idx [0:1023];
    int pl_w   [0:1023];
    int tx_cnt = 0, pl_cnt = 0, rd_cnt = 0, onehot_err = 0, underflow = 0;
    logic [5:0] prev_cmd = 6'd0;
    int run_len = 0;

    uart_cmd_parser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .rx_rdata  (rx_rdata),
        .rx_rd     (rx_rd),
        .tx_full   (tx_full),
        .tx_wdata  (tx_wdata),
        .tx_wr     (tx_wr),
        .cmd_pulse (cmd_pulse),
        .mode_sel  (mode_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: FIFO pops, echo capture, pulse run-length logging
    always @(negedge clk) begin
        if (rx_rd) begin
            if (rd_ptr == wr_ptr) underflow++;
            else begin
                rx_rdata = mem[rd_ptr % 256];
                rd_ptr++;
            end
            rd_cnt++;
        end
        if (tx_wr) begin
            tx_log[tx_cnt % 1024] = tx_wdata;
            tx_cnt++;
        end
        if ($countones(cmd_pulse) > 1) onehot_err++;
        if (cmd_pulse != prev_cmd) begin
            if (prev_cmd != 6'd0) begin
                pl_idx[pl_cnt % 1024] = $clog2(prev_cmd);
                pl_w[pl_cnt % 1024]   = run_len;
                pl_cnt++;
            end
            run_len = (cmd_pulse != 6'd0) ? 1 : 0;
        end else if (cmd_pulse != 6'd0) begin
            run_len++;
        end
        prev_cmd = cmd_pulse;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push a byte in the low clock phase so no edge sees a half-updated FIFO
    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr++;
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        for (int c = 0; c < 3000 && quiet < 12; c++) begin
            @(negedge clk);
            if (rx_empty && !rx_rd && cmd_pulse == 6'd0 && !tx_wr) quiet++;
            else quiet = 0;
        end
        if (quiet < 12) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
    endtask

    // Reference model, derived from the command rules with plain arithmetic
    function automatic int ref_bit(input logic [7:0] b);
        string cmds = "RCHMST";
        logic [7:0] u;
        u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
        for (int i = 0; i < 6; i++) if (u == cmds[i]) return i;
        return -1;
    endfunction

    function automatic bit ref_mode(input logic [7:0] b);
        return (b == 8'h57) || (b == 8'h77);
    endfunction

    function automatic logic [7:0] ref_echo(input logic [7:0] b);
        if (ref_bit(b) >= 0 || ref_mode(b) || b == 8'h0D || b == 8'h0A) return b;
        return 8'h3F;
    endfunction

    typedef struct {
        logic [7:0] data;
        int         exp_bit;
        bit         toggle;
        logic [7:0] exp_echo;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int pb, tb_, rb;
        bit exp_mode;
        logic [7:0] seq [10];
        int exp_idx [10];
        int n_exp, n_echo;
        logic [7:0] exp_tx [10];
        bit found;
        int cnt_a, cnt_b;

        tbl[0]  = '{8'h52, 0, 1'b0, 8'h52};
        tbl[1]  = '{8'h72, 0, 1'b0, 8'h72};
        tbl[2]  = '{8'h43, 1, 1'b0, 8'h43};
        tbl[3]  = '{8'h63, 1, 1'b0, 8'h63};
        tbl[4]  = '{8'h48, 2, 1'b0, 8'h48};
        tbl[5]  = '{8'h68, 2, 1'b0, 8'h68};
        tbl[6]  = '{8'h4D, 3, 1'b0, 8'h4D};
        tbl[7]  = '{8'h6D, 3, 1'b0, 8'h6D};
        tbl[8]  = '{8'h53, 4, 1'b0, 8'h53};
        tbl[9]  = '{8'h73, 4, 1'b0, 8'h73};
        tbl[10] = '{8'h54, 5, 1'b0, 8'h54};
        tbl[11] = '{8'h74, 5, 1'b0, 8'h74};
        tbl[12] = '{8'h57, -1, 1'b1, 8'h57};
        tbl[13] = '{8'h77, -1, 1'b1, 8'h77};
        tbl[14] = '{8'h41, -1, 1'b0, 8'h3F};
        tbl[15] = '{8'h0D, -1, 1'b0, 8'h0D};
        tbl[16] = '{8'h0A, -1, 1'b0, 8'h0A};
        tbl[17] = '{8'h00, -1, 1'b0, 8'h3F};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_rd", rx_rd, 0);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_wdata", tx_wdata, 8'h00);
        chk("rst_cmd", cmd_pulse, 6'd0);
        chk("rst_mode", mode_sel, 0);
        #1 rst = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_rd) cnt_a++;
        end
        chk("idle_no_pop", cnt_a, 0);

        // Latency for 'R': empty drops before edge k
        #1 push(8'h52);
        tb_ = tx_cnt;
        @(negedge clk); chk("lat_n0_rd", rx_rd, 0);
        @(negedge clk); chk("lat_n1_rd", rx_rd, 1);
        @(negedge clk); chk("lat_n2_rd", rx_rd, 0);
        @(negedge clk); chk("lat_n3_cmd", cmd_pulse, 6'd0);
        for (int i = 4; i < 8; i++) begin
            @(negedge clk); chk("lat_pulse_cmd", cmd_pulse, 6'b000001);
        end
        @(negedge clk); chk("lat_n8_cmd", cmd_pulse, 6'd0);
        @(negedge clk);
`ifdef UART_CMD_ECHO_EN
        chk("lat_echo_wr", tx_wr, 1);
        chk("lat_echo_data", tx_wdata, 8'h52);
`else
        chk("lat_no_echo", tx_wr, 0);
`endif
        wait_quiet("lat");

        // Table-driven single bytes
        exp_mode = 1'b0;
        foreach (tbl[i]) begin
            pb = pl_cnt; tb_ = tx_cnt; rb = rd_cnt;
            @(negedge clk); #1 push(tbl[i].data);
            wait_quiet("tbl");
            exp_mode ^= tbl[i].toggle;
            chk("tbl_pops", rd_cnt - rb, 1);
            if (tbl[i].exp_bit >= 0) begin
                chk("tbl_npulse", pl_cnt - pb, 1);
                chk("tbl_bit", pl_idx[pb % 1024], tbl[i].exp_bit);
                chk("tbl_width", pl_w[pb % 1024], 4);
            end else begin
                chk("tbl_npulse", pl_cnt - pb, 0);
            end
            chk("tbl_mode", mode_sel, exp_mode);
`ifdef UART_CMD_ECHO_EN
            chk("tbl_necho", tx_cnt - tb_, 1);
            chk("tbl_echo", tx_log[tb_ % 1024], tbl[i].exp_echo);
`else
            chk("tbl_necho", tx_cnt - tb_, 0);
`endif
        end

        // 'w' then 'W','t'
        @(negedge clk); #1 push(8'h77);
        wait_quiet("w1");
        chk("wWt_mode1", mode_sel, 1);
        pb = pl_cnt;
        @(negedge clk); #1 push(8'h57); push(8'h74);
        wait_quiet("wWt");
        chk("wWt_mode0", mode_sel, 0);
        chk("wWt_npulse", pl_cnt - pb, 1);
        chk("wWt_bit", pl_idx[pb % 1024], 5);
        chk("wWt_width", pl_w[pb % 1024], 4);

        // Back-pressure on echo while 'S' is processed
        pb = pl_cnt; tb_ = tx_cnt;
        @(negedge clk); #1 tx_full = 1'b1; push(8'h53); push(8'h52);
`ifdef UART_CMD_ECHO_EN
        for (int c = 0; c < 100 && pl_cnt == pb; c++) @(negedge clk);
        chk("full_s_npulse", pl_cnt - pb, 1);
        chk("full_s_bit", pl_idx[pb % 1024], 4);
        chk("full_s_width", pl_w[pb % 1024], 4);
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rx_rd) cnt_a++;
            if (tx_wr) cnt_b++;
        end
        chk("full_hold_rd", cnt_a, 0);
        chk("full_hold_wr", cnt_b, 0);
        chk("full_fifo_nonempty", rx_empty, 0);
        #1 tx_full = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (tx_wr) found = 1'b1;
        end
        chk("full_release_wr", found, 1);
        chk("full_release_data", tx_wdata, 8'h53);
        @(negedge clk);
        chk("full_next_pop", rx_rd, 1);
        wait_quiet("full");
        chk("full_r_npulse", pl_cnt - pb, 2);
        chk("full_r_bit", pl_idx[(pb + 1) % 1024], 0);
`else
        wait_quiet("full");
        chk("full_ign_npulse", pl_cnt - pb, 2);
        chk("full_ign_bit0", pl_idx[pb % 1024], 4);
        chk("full_ign_bit1", pl_idx[(pb + 1) % 1024], 0);
        chk("full_ign_necho", tx_cnt - tb_, 0);
        #1 tx_full = 1'b0;
`endif

        // Reset in the middle of an 'H' pulse, with mode_sel set
        @(negedge clk); #1 push(8'h57);
        wait_quiet("rst_w");
        chk("rst_pre_mode", mode_sel, 1);
        @(negedge clk); #1 push(8'h48);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (cmd_pulse[2]) found = 1'b1;
        end
        chk("rst_h_seen", found, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_cmd", cmd_pulse, 6'd0);
        chk("rst_async_mode", mode_sel, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        pb = pl_cnt; rb = rd_cnt;
        @(negedge clk); #1 push(8'h43);
        wait_quiet("rst_c");
        chk("rst_after_pops", rd_cnt - rb, 1);
        chk("rst_after_npulse", pl_cnt - pb, 1);
        chk("rst_after_bit", pl_idx[pb % 1024], 1);
        chk("rst_after_width", pl_w[pb % 1024], 4);
        chk("rst_after_mode", mode_sel, 0);

        // Randomized streams vs reference model
        exp_mode = mode_sel;
        for (int r = 0; r < 6; r++) begin
            string alpha = "RCHMSTW";
            pb = pl_cnt; tb_ = tx_cnt; rb = rd_cnt;
            n_exp = 0; n_echo = 0;
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 9) < 7) begin
                    seq[i] = alpha[$urandom_range(0, 6)];
                    if ($urandom_range(0, 1) == 1) seq[i] = seq[i] + 8'h20;
                end else begin
                    seq[i] = 8'($urandom_range(0, 255));
                end
                if (ref_bit(seq[i]) >= 0) begin
                    exp_idx[n_exp] = ref_bit(seq[i]);
                    n_exp++;
                end
                if (ref_mode(seq[i])) exp_mode = ~exp_mode;
                exp_tx[n_echo] = ref_echo(seq[i]);
                n_echo++;
            end
            @(negedge clk);
            #1;
            for (int i = 0; i < 10; i++) push(seq[i]);
            wait_quiet("rnd");
            chk("rnd_pops", rd_cnt - rb, 10);
            chk("rnd_npulse", pl_cnt - pb, n_exp);
            for (int i = 0; i < n_exp && i < pl_cnt - pb; i++) begin
                chk("rnd_bit", pl_idx[(pb + i) % 1024], exp_idx[i]);
                chk("rnd_width", pl_w[(pb + i) % 1024], 4);
            end
            chk("rnd_mode", mode_sel, exp_mode);
`ifdef UART_CMD_ECHO_EN
            chk("rnd_necho", tx_cnt - tb_, n_echo);
            for (int i = 0; i < n_echo && i < tx_cnt - tb_; i++)
                chk("rnd_echo", tx_log[(tb_ + i) % 1024], exp_tx[i]);
`else
            chk("rnd_necho", tx_cnt - tb_, 0);
`endif
        end

        chk("onehot_violations", onehot_err, 0);
        chk("fifo_underflow", underflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
